lcd_spi_feeder: RTL and testbench
=================================

# lcd_spi_feeder

Wishbone-slave SPI master that feeds the memory-LCD driver's SPI RX port. Firmware writes pixel/command bytes over Wishbone into a small TX FIFO. The block serialises them as SPI mode 0, MSB first, on the pins that loop into the driver's `i_spi_mosi`/`i_spi_cs_n`/`i_spi_clk`. It pauses at byte boundaries whenever the driver deasserts `o_spi_cts`.

## Interface
Reset is synchronous, active-high, on `i_reset`, sampled on rising `i_clk`; single clock domain `i_clk`.

Parameters:
- `FIFO_DEPTH`, 8: TX FIFO entries (power of 2, ≥2).
- `DIV_RESET`, 4: reset value of the SCK half-period divider.

Ports:
- `i_clk`  in  1  system clock (wb_clk_i).
- `i_reset`  in  1  sync active-high reset.
- `i_wb_cyc`, `i_wb_stb`, `i_wb_we`  in  1  Wishbone cycle/strobe/write.
- `i_wb_sel`  in  4  byte select.
- `i_wb_adr`  in  32  address; only bits [3:2] decoded.
- `i_wb_dat`  in  32  write data.
- `o_wb_ack`  out  1  ack pulse.
- `o_wb_dat`  out  32  read data.
- `o_spi_mosi`, `o_spi_cs_n`, `o_spi_clk`  out  1  SPI to driver.
- `i_spi_cts`  in  1  clear-to-send from driver (asynchronous pad input).
- `o_irq`  out  1  FIFO-empty interrupt.

## Operation
Registers (adr[3:2]):
- 0 DATA
  - Write with sel[0]: push dat[7:0].
  - Write while full: byte dropped, OVF set.
  - Read returns 0.
- 1 STATUS, read-only except OVF.
  - [4:0] level; [8] busy (state≠IDLE); [9] cts_sync; [10] OVF sticky; [11] full; [12] empty.
  - Writing 1 to bit 10 clears OVF.
- 2 CTRL, R/W.
  - [7:0] DIV; DIV=0 behaves as 1.
  - [8] irq_en, reset 0.
- 3: reads 0, writes ignored.

Wishbone behaviour:
- Ack is a single-cycle pulse one cycle after `cyc&stb`. No ack is issued in a cycle where `o_wb_ack` is already high.
- Read data is registered together with the ack.

`i_spi_cts` passes through a 2-flop synchroniser to produce cts_sync.

FSM (half-period H = DIV clocks, counted by a down-counter):
- IDLE
  - cs_n=1, sck=0, mosi=0.
  - If !empty & cts_sync: pop byte into shift reg, cs_n→0, → SETUP.
- SETUP: hold H; mosi = bit7; → SHIFT_LO.
- SHIFT_LO: sck=0 for H; → SHIFT_HI (sck rises).
- SHIFT_HI
  - sck=1 for H.
  - At end: sck falls, shift left, bit count+1.
  - After 8 bits → GAP; otherwise → SHIFT_LO, with mosi updated on the falling edge.
- GAP (cs_n stays 0)
  - If !empty & cts_sync: pop, mosi=bit7, → SHIFT_LO.
  - If empty: → TRAIL.
  - If !cts_sync & !empty: wait in GAP indefinitely.
- TRAIL: cs_n=0 for H, then cs_n→1 → IDLE. IDLE holds cs_n high for a minimum of H before the next frame.

Other rules:
- Consecutive bytes share one CS frame while the FIFO stays non-empty.
- `o_irq` = irq_en & empty, registered.

## Timing
- Reset values:
  - ack=0, dat=0, cs_n=1, sck=0, mosi=0, irq=0.
  - FIFO flushed, OVF=0, DIV=DIV_RESET, irq_en=0, state=IDLE.
- Reset mid-byte aborts immediately. cs_n goes high on the cycle after reset is sampled, and the partial byte is discarded.
- DATA write to first SCK rise: ack +1, FIFO write +1, IDLE pop +1, SETUP H, SHIFT_LO H. Total 2+2H cycles when cts_sync is already high.
- One byte occupies 16H clocks. A single-byte frame has cs_n low for 18H.
- Push and pop in the same cycle at full: accepted, level unchanged, no OVF.
- Push and pop in the same cycle at empty: not possible, because pop requires !empty at the sample.
- CTRL DIV change takes effect at the next counter reload. It never truncates the current half-period.
- A CTS drop mid-byte does not stop the byte; CTS is checked only in IDLE and GAP.

## Structure
- `lcd_feeder_pkg`
  - Register offsets (`REG_DATA`, `REG_STATUS`, `REG_CTRL`).
  - STATUS bit indices.
  - FSM state enum: IDLE, SETUP, SHIFT_LO, SHIFT_HI, GAP, TRAIL.
- Sub-module `lcd_feeder_fifo`: synchronous FIFO with push/pop/full/empty/level, parameterised on `FIFO_DEPTH`.
- Top contains the Wishbone regs, synchroniser, divider and FSM.

## Test plan
- Reset, then STATUS read → 0x1000 (empty) with cts tied 0. All SPI outputs are idle.
- DIV=1, cts=1, write 0xA5 → cs_n low 18 clocks; bits 1,0,1,0,0,1,0,1 sampled on SCK rises; then irq_en fires `o_irq`.
- Write 0x12, 0x34, 0x56 back-to-back → a single CS frame of 24 SCK rises, no cs_n glitch between bytes.
- Fill 8 bytes with cts=0, then write a 9th → STATUS level=8, full=1, OVF=1, no SPI activity. Clear OVF, raise cts → 8 bytes sent.
- Drop cts during byte 1 of 2 → byte 1 completes, then GAP with cs_n low and sck low. Raising cts resumes byte 2 after 2-cycle sync.
- Assert `i_reset` mid-byte → cs_n=1 and sck=0 next cycle, FIFO empty, DIV=DIV_RESET.

Source files
------------

// File: rtl/lcd_feeder_pkg.sv
// Shared definitions for the LCD SPI feeder: register map, STATUS layout, FSM states.
package lcd_feeder_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int ST_BUSY  = 8;
  localparam int ST_CTS   = 9;
  localparam int ST_OVF   = 10;
  localparam int ST_FULL  = 11;
  localparam int ST_EMPTY = 12;

  localparam int CTRL_IRQ_EN = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_LO,
    SHIFT_HI,
    GAP,
    TRAIL
  } feeder_state_e;

  // A programmed divider of zero still has to give a one-clock half period.
  function automatic logic [7:0] eff_div(input logic [7:0] div);
    return (div == 8'd0) ? 8'd1 : div;
  endfunction

endpackage

// File: rtl/lcd_spi_feeder_if.sv
// Wishbone slave bundle for the LCD SPI feeder; names follow the slave's view.
interface lcd_spi_feeder_if;
  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic        i_wb_we;
  logic [3:0]  i_wb_sel;
  logic [31:0] i_wb_adr;
  logic [31:0] i_wb_dat;
  logic        o_wb_ack;
  logic [31:0] o_wb_dat;

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_sel, i_wb_adr, i_wb_dat,
    input  o_wb_ack, o_wb_dat
  );

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_sel, i_wb_adr, i_wb_dat,
    output o_wb_ack, o_wb_dat
  );
endinterface

// File: rtl/lcd_feeder_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO is accepted only alongside a pop.
module lcd_feeder_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int WIDTH      = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            pop_data,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign level    = count;
  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/lcd_spi_feeder.sv
// Wishbone-fed SPI mode-0 master that streams FIFO bytes into the memory-LCD driver,
// keeping one CS frame open while bytes keep arriving and pausing at byte gaps on CTS.
module lcd_spi_feeder
  import lcd_feeder_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_RESET  = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  lcd_spi_feeder_if.slave    wb,
  output logic               o_spi_mosi,
  output logic               o_spi_cs_n,
  output logic               o_spi_clk,
  input  logic               i_spi_cts,
  output logic               o_irq
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          wb_req;
  logic [1:0]    reg_sel;
  logic          ack_q;
  logic [31:0]   rdat_q;
  logic [31:0]   rdata;
  logic [31:0]   status;
  logic          push_q;
  logic [7:0]    push_data_q;
  logic          ovf;
  logic          irq_en;
  logic [7:0]    div;
  logic          cts_meta;
  logic          cts_sync;
  logic          irq_q;

  logic          fifo_full;
  logic          fifo_empty;
  logic [LW-1:0] fifo_level;
  logic [7:0]    fifo_rd;

  feeder_state_e state;
  feeder_state_e state_next;
  logic [7:0]    cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          cs_n_q;
  logic          sck_q;
  logic          pop;
  logic          reload;
  logic          cnt_dec;
  logic          shift_en;
  logic          half_done;
  logic          can_send;

  logic          unused_wb;
  assign unused_wb = ^{wb.i_wb_adr[31:4], wb.i_wb_adr[1:0], wb.i_wb_dat[31:11],
                       wb.i_wb_dat[9], wb.i_wb_sel[3:2]};

  assign wb_req  = wb.i_wb_cyc & wb.i_wb_stb & ~ack_q;
  assign reg_sel = wb.i_wb_adr[3:2];

  always_comb begin
    status           = '0;
    status[4:0]      = 5'(fifo_level);
    status[ST_BUSY]  = (state != IDLE);
    status[ST_CTS]   = cts_sync;
    status[ST_OVF]   = ovf;
    status[ST_FULL]  = fifo_full;
    status[ST_EMPTY] = fifo_empty;
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_STATUS: rdata = status;
      REG_CTRL:   rdata = {23'd0, irq_en, div};
      default:    rdata = '0;
    endcase
  end

  // DATA writes are pipelined one cycle into the FIFO so overflow is judged at the real push.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ack_q       <= 1'b0;
      rdat_q      <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      ovf         <= 1'b0;
      irq_en      <= 1'b0;
      div         <= 8'(DIV_RESET);
    end else begin
      ack_q  <= wb_req;
      push_q <= 1'b0;
      if (push_q && fifo_full && !pop) ovf <= 1'b1;
      if (wb_req) begin
        rdat_q <= rdata;
        if (wb.i_wb_we) begin
          case (reg_sel)
            REG_DATA: begin
              if (wb.i_wb_sel[0]) begin
                push_q      <= 1'b1;
                push_data_q <= wb.i_wb_dat[7:0];
              end
            end
            REG_STATUS: if (wb.i_wb_sel[1] && wb.i_wb_dat[ST_OVF]) ovf <= 1'b0;
            REG_CTRL: begin
              if (wb.i_wb_sel[0]) div    <= wb.i_wb_dat[7:0];
              if (wb.i_wb_sel[1]) irq_en <= wb.i_wb_dat[CTRL_IRQ_EN];
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign wb.o_wb_ack = ack_q;
  assign wb.o_wb_dat = rdat_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cts_meta <= 1'b0;
      cts_sync <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      cts_meta <= i_spi_cts;
      cts_sync <= cts_meta;
      irq_q    <= irq_en & fifo_empty;
    end
  end

  lcd_feeder_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .WIDTH     (8)
  ) u_fifo (
    .clk      (i_clk),
    .reset    (i_reset),
    .push     (push_q),
    .push_data(push_data_q),
    .pop      (pop),
    .pop_data (fifo_rd),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  // The GAP decision is also taken at the end of the last bit, so back-to-back bytes and
  // frame ends cost no dead cycle; GAP itself is only occupied while waiting for CTS.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    reload     = 1'b0;
    cnt_dec    = 1'b0;
    shift_en   = 1'b0;
    half_done  = (cnt == 8'd0);
    can_send   = ~fifo_empty & cts_sync;
    case (state)
      IDLE: begin
        if (!half_done) cnt_dec = 1'b1;
        else if (can_send) begin
          pop        = 1'b1;
          reload     = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP, SHIFT_LO, TRAIL: begin
        if (!half_done) cnt_dec = 1'b1;
        else begin
          reload = 1'b1;
          case (state)
            SETUP:    state_next = SHIFT_LO;
            SHIFT_LO: state_next = SHIFT_HI;
            default:  state_next = IDLE;
          endcase
        end
      end
      SHIFT_HI: begin
        if (!half_done) cnt_dec = 1'b1;
        else begin
          shift_en = 1'b1;
          if (bit_cnt != 3'd7) begin
            reload     = 1'b1;
            state_next = SHIFT_LO;
          end else if (fifo_empty) begin
            reload     = 1'b1;
            state_next = TRAIL;
          end else if (cts_sync) begin
            pop        = 1'b1;
            reload     = 1'b1;
            state_next = SHIFT_LO;
          end else begin
            state_next = GAP;
          end
        end
      end
      GAP: begin
        if (fifo_empty) begin
          reload     = 1'b1;
          state_next = TRAIL;
        end else if (cts_sync) begin
          pop        = 1'b1;
          reload     = 1'b1;
          state_next = SHIFT_LO;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      cs_n_q  <= 1'b1;
      sck_q   <= 1'b0;
    end else begin
      cs_n_q <= (state_next == IDLE);
      sck_q  <= (state_next == SHIFT_HI);
      if (reload)       cnt <= eff_div(div) - 8'd1;
      else if (cnt_dec) cnt <= cnt - 8'd1;
      if (pop) begin
        shreg   <= fifo_rd;
        bit_cnt <= '0;
      end else if (shift_en) begin
        shreg   <= {shreg[6:0], 1'b0};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  assign o_spi_mosi = shreg[7];
  assign o_spi_cs_n = cs_n_q;
  assign o_spi_clk  = sck_q;
  assign o_irq      = irq_q;

endmodule

// File: tb/tb_lcd_spi_feeder.sv
// Directed bench for lcd_spi_feeder: an SPI receiver/scoreboard checks every byte and pin
// rule each cycle, while directed sequences pin latencies, frame lengths and STATUS values.
module tb_lcd_spi_feeder;
  localparam int FIFO_DEPTH = 8;
  localparam int DIV_RESET  = 4;

  logic clk = 1'b0;
  logic i_reset;
  logic i_spi_cts;
  logic mosi, cs_n, sck, irq;
  logic rst_q = 1'b1;

  lcd_spi_feeder_if wb();

  lcd_spi_feeder #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .DIV_RESET (DIV_RESET)
  ) dut (
    .i_clk     (clk),
    .i_reset   (i_reset),
    .wb        (wb),
    .o_spi_mosi(mosi),
    .o_spi_cs_n(cs_n),
    .o_spi_clk (sck),
    .i_spi_cts (i_spi_cts),
    .o_irq     (irq)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int div_h       = DIV_RESET;
  logic [7:0] sb[$];

  logic prev_cs = 1'b1, prev_sck = 1'b0, prev_mosi = 1'b0;
  int   low_cnt = 0, cur_rises = 0, last_len = 0, last_rises = 0, frame_cnt = 0;
  int   high_run = 0, bits = 0;
  logic [7:0] rx = '0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) rst_q <= i_reset;

  // Receiver model: what an SPI mode-0 slave sees, judged against the bytes firmware queued.
  always @(negedge clk) begin
    if (!cs_n) begin
      if (prev_cs) low_cnt = 0;
      low_cnt++;
    end else if (!prev_cs) begin
      last_len   = low_cnt;
      last_rises = cur_rises;
      cur_rises  = 0;
      frame_cnt++;
    end
    if (cs_n) check_output("idle_pins", {30'd0, sck, mosi}, 32'd0);
    if (rst_q) begin
      bits     = 0;
      high_run = 0;
    end else begin
      if (sck && !prev_sck && !cs_n) begin
        rx = {rx[6:0], mosi};
        bits++;
        cur_rises++;
        if (bits == 8) begin
          bits = 0;
          check_output("rx_byte_expected", 32'(sb.size() > 0), 32'd1);
          if (sb.size() > 0) check_output("rx_byte", 32'(rx), 32'(sb.pop_front()));
        end
      end
      if (sck && prev_sck) check_output("mosi_stable_sck_high", 32'(mosi), 32'(prev_mosi));
      if (sck) high_run++;
      else if (prev_sck) begin
        check_output("sck_high_len", high_run, div_h);
        high_run = 0;
      end
    end
    prev_cs   = cs_n;
    prev_sck  = sck;
    prev_mosi = mosi;
  end

  task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                           output logic [31:0] rdat);
    int n;
    @(negedge clk);
    wb.i_wb_cyc = 1'b1;
    wb.i_wb_stb = 1'b1;
    wb.i_wb_we  = we;
    wb.i_wb_adr = adr;
    wb.i_wb_dat = wdat;
    wb.i_wb_sel = 4'hF;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wb.o_wb_ack && n < 8);
    check_output("wb_ack", 32'(wb.o_wb_ack), 32'd1);
    rdat = wb.o_wb_dat;
    wb.i_wb_cyc = 1'b0;
    wb.i_wb_stb = 1'b0;
    wb.i_wb_we  = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] wdat);
    logic [31:0] d;
    wb_access(1'b1, adr, wdat, d);
  endtask

  task automatic read_check(input string name, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] d;
    wb_access(1'b0, adr, 32'd0, d);
    check_output(name, d, exp);
  endtask

  task automatic write_byte(input logic [7:0] b);
    if (sb.size() < FIFO_DEPTH) sb.push_back(b);
    wb_write(32'h0, {24'd0, b});
  endtask

  task automatic measure_first_rise(input string name, input int exp);
    int lat = 0;
    while (!sck && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check_output(name, lat, exp);
  endtask

  task automatic wait_frame(input int start_cnt);
    int n = 0;
    while (frame_cnt == start_cnt && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check_output("frame_done", 32'(frame_cnt != start_cnt), 32'd1);
  endtask

  task automatic wait_rises(input int target);
    int n = 0;
    while (cur_rises < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_output("rises_reached", 32'(cur_rises >= target), 32'd1);
  endtask

  initial begin
    int start;
    i_reset     = 1'b1;
    i_spi_cts   = 1'b0;
    wb.i_wb_cyc = 1'b0;
    wb.i_wb_stb = 1'b0;
    wb.i_wb_we  = 1'b0;
    wb.i_wb_sel = 4'h0;
    wb.i_wb_adr = '0;
    wb.i_wb_dat = '0;
    repeat (3) @(negedge clk);
    i_reset = 1'b0;
    @(negedge clk);
    check_output("reset_pins", {27'd0, wb.o_wb_ack, cs_n, sck, mosi, irq}, 32'h08);
    read_check("reset_status", 32'h4, 32'h1000);
    read_check("reset_ctrl", 32'h8, 32'h4);
    read_check("data_reads_zero", 32'h0, 32'h0);
    read_check("reg3_reads_zero", 32'hC, 32'h0);

    // Single byte at DIV=1.
    wb_write(32'h8, 32'h1);
    div_h     = 1;
    i_spi_cts = 1'b1;
    repeat (4) @(negedge clk);
    start = frame_cnt;
    write_byte(8'hA5);
    measure_first_rise("a5_first_rise", 4);
    wait_frame(start);
    check_output("a5_cs_low", last_len, 18);
    check_output("a5_rises", last_rises, 8);
    check_output("irq_before_en", 32'(irq), 32'd0);
    wb_write(32'h8, 32'h101);
    @(negedge clk);
    check_output("irq_fires", 32'(irq), 32'd1);

    // Three bytes share one frame.
    start = frame_cnt;
    write_byte(8'h12);
    write_byte(8'h34);
    write_byte(8'h56);
    wait_frame(start);
    check_output("burst_rises", last_rises, 24);
    check_output("burst_cs_low", last_len, 50);
    repeat (20) @(negedge clk);
    check_output("burst_one_frame", frame_cnt, start + 1);

    // Fill with CTS low, overflow, then drain.
    i_spi_cts = 1'b0;
    repeat (4) @(negedge clk);
    start = frame_cnt;
    for (int i = 1; i <= 9; i++) write_byte(8'(i * 17));
    read_check("ovf_status", 32'h4, 32'h0C08);
    check_output("ovf_no_spi", frame_cnt, start);
    wb_write(32'h4, 32'h400);
    read_check("ovf_cleared", 32'h4, 32'h0808);
    i_spi_cts = 1'b1;
    wait_frame(start);
    check_output("drain_rises", last_rises, 64);
    check_output("drain_cs_low", last_len, 130);
    check_output("drain_sb_empty", sb.size(), 0);

    // CTS drop during the first of two bytes parks in GAP.
    start = frame_cnt;
    write_byte(8'hC3);
    write_byte(8'h3C);
    wait_rises(1);
    i_spi_cts = 1'b0;
    wait_rises(8);
    repeat (10) @(negedge clk);
    check_output("gap_pins", {30'd0, cs_n, sck}, 32'd0);
    check_output("gap_rises", cur_rises, 8);
    i_spi_cts = 1'b1;
    measure_first_rise("gap_resume", 4);
    wait_frame(start);
    check_output("gap_frame_rises", last_rises, 16);

    // Slower divider, then DIV=0 behaving as 1.
    wb_write(32'h8, 32'h3);
    div_h = 3;
    start = frame_cnt;
    write_byte(8'h5A);
    measure_first_rise("div3_first_rise", 8);
    wait_frame(start);
    check_output("div3_cs_low", last_len, 54);
    wb_write(32'h8, 32'h0);
    div_h = 1;
    start = frame_cnt;
    write_byte(8'h81);
    measure_first_rise("div0_first_rise", 4);
    wait_frame(start);
    check_output("div0_cs_low", last_len, 18);

    // Reset in the middle of a byte.
    wb_write(32'h8, 32'h2);
    div_h = 2;
    write_byte(8'hFF);
    write_byte(8'hEE);
    wait_rises(3);
    i_reset = 1'b1;
    sb.delete();
    @(negedge clk);
    check_output("reset_abort_pins", {30'd0, cs_n, sck}, 32'h2);
    i_reset = 1'b0;
    div_h   = DIV_RESET;
    repeat (3) @(negedge clk);
    read_check("reset_abort_status", 32'h4, 32'h1200);
    read_check("reset_abort_ctrl", 32'h8, 32'h4);
    start = frame_cnt;
    repeat (40) @(negedge clk);
    check_output("reset_abort_quiet", frame_cnt, start);
    check_output("final_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish before 500000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
